// File: rtl/ms_inverse_scheduler.sv
// Round-robin scheduler sharing one mid/side inverse core among NUM_CH stereo streams.
// Optional saturation flags are built when MS_SAT_FLAG_EN is defined.
module ms_inverse_scheduler #(
    parameter int NUM_CH = 4,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      in_valid,
    output logic [NUM_CH-1:0]      in_ready,
    input  logic [16*NUM_CH-1:0]   in_mid,
    input  logic [16*NUM_CH-1:0]   in_side,
    input  logic [NUM_CH-1:0]      ch_enable,
    output logic                   core_ce,
    output logic                   core_enable,
    output logic [15:0]            core_mid,
    output logic [15:0]            core_side,
    input  logic [15:0]            core_L,
    input  logic [15:0]            core_R,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_L,
    output logic [15:0]            out_R,
    output logic [CH_W-1:0]        out_ch,
    output logic [1:0]             out_sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [CH_W-1:0]   last_grant_r;
    logic [15:0]       op_mid_r;
    logic [15:0]       op_side_r;
    logic              op_en_r;
    logic [CH_W-1:0]   op_ch_r;

    logic              arb_en_s;
    logic              grant_any_s;
    logic              grant_s;
    logic [CH_W-1:0]   grant_idx_s;

    // Round-robin search: the descending loop leaves the nearest requester after last_grant.
    always_comb begin
        arb_en_s    = (state_r == IDLE) || ((state_r == OUT) && out_ready);
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (in_valid[(int'(last_grant_r) + k) % NUM_CH]) begin
                grant_any_s = 1'b1;
                grant_idx_s = CH_W'((int'(last_grant_r) + k) % NUM_CH);
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        grant_s = arb_en_s && grant_any_s;
    end

    // One-hot handshake grant, only in arbitration cycles.
    always_comb begin
        in_ready = '0;
        if (grant_s) begin
            in_ready[grant_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                state_next_s = OUT;
            end
            OUT: begin
                if (!out_ready) begin
                    state_next_s = OUT;
                end else if (grant_s) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Capture the winner's operands and remember it for the next search.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= CH_W'(NUM_CH - 1);
            op_mid_r     <= 16'h0000;
            op_side_r    <= 16'h0000;
            op_en_r      <= 1'b0;
            op_ch_r      <= '0;
        end else if (grant_s) begin
            last_grant_r <= grant_idx_s;
            op_mid_r     <= in_mid[{grant_idx_s, 4'b0000} +: 16];
            op_side_r    <= in_side[{grant_idx_s, 4'b0000} +: 16];
            op_en_r      <= ch_enable[grant_idx_s];
            op_ch_r      <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
            op_mid_r     <= op_mid_r;
            op_side_r    <= op_side_r;
            op_en_r      <= op_en_r;
            op_ch_r      <= op_ch_r;
        end
    end

    assign core_ce     = (state_r == ISSUE);
    assign core_mid    = op_mid_r;
    assign core_side   = op_side_r;
    assign core_enable = op_en_r;
    assign out_valid   = (state_r == OUT);
    assign out_L       = core_L;
    assign out_R       = core_R;
    assign out_ch      = op_ch_r;

`ifdef MS_SAT_FLAG_EN
    logic [16:0] sum_s;
    logic [16:0] dif_s;
    logic [1:0]  sat_r;

    function automatic logic ovf17(input logic [16:0] v);
        return v[16] ^ v[15];
    endfunction

    assign sum_s = {op_mid_r[15], op_mid_r} + {op_side_r[15], op_side_r};
    assign dif_s = {op_mid_r[15], op_mid_r} - {op_side_r[15], op_side_r};

    // Flags are evaluated alongside the core strobe so they line up with out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_r <= 2'b00;
        end else if (state_r == ISSUE) begin
            sat_r <= op_en_r ? {ovf17(dif_s), ovf17(sum_s)} : 2'b00;
        end else begin
            sat_r <= sat_r;
        end
    end

    assign out_sat = sat_r;
`else
    assign out_sat = 2'b00;
`endif

endmodule

// File: tb/tb_ms_inverse_scheduler.sv
// Directed bench for ms_inverse_scheduler with a transaction-level scoreboard and a core model.
module tb_ms_inverse_scheduler;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        in_valid = 4'h0;
    logic [3:0]        in_ready;
    logic [63:0]       in_mid = 64'h0;
    logic [63:0]       in_side = 64'h0;
    logic [3:0]        ch_enable = 4'hF;
    logic              core_ce;
    logic              core_enable;
    logic [15:0]       core_mid;
    logic [15:0]       core_side;
    logic [15:0]       core_L = 16'h0000;
    logic [15:0]       core_R = 16'h0000;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [15:0]       out_L;
    logic [15:0]       out_R;
    logic [CH_W-1:0]   out_ch;
    logic [1:0]        out_sat;

    int errors = 0;
    int checks = 0;
    int grant_q[$];

    ms_inverse_scheduler #(.NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mid(in_mid), .in_side(in_side), .ch_enable(ch_enable),
        .core_ce(core_ce), .core_enable(core_enable), .core_mid(core_mid),
        .core_side(core_side), .core_L(core_L), .core_R(core_R),
        .out_valid(out_valid), .out_ready(out_ready), .out_L(out_L),
        .out_R(out_R), .out_ch(out_ch), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767) return 16'h7FFF;
        else if (v < -32768) return 16'h8000;
        else return v[15:0];
    endfunction

    // {sat[1:0], L, R} of the inverse mid/side transform
    function automatic logic [33:0] core_fn(input logic [15:0] m, input logic [15:0] s, input logic en);
        int sum;
        int dif;
        logic [1:0] f;
        sum = int'($signed(m)) + int'($signed(s));
        dif = int'($signed(m)) - int'($signed(s));
        if (!en) return {2'b00, m, s};
        f[0] = (sum > 32767) || (sum < -32768);
        f[1] = (dif > 32767) || (dif < -32768);
        return {f, sat16(sum), sat16(dif)};
    endfunction

    // Environment model of the registered core.
    logic [33:0] core_res;
    always @(posedge clk) begin
        if (core_ce) begin
            core_res = core_fn(core_mid, core_side, core_enable);
            core_L <= core_res[31:16];
            core_R <= core_res[15:0];
        end
    end

    // Scoreboard: transaction-level expectations checked every cycle.
    int          m_last = NUM_CH - 1;
    bit          ce_exp = 1'b0;
    bit          have = 1'b0;
    logic [33:0] pend_res;
    logic [33:0] have_res;
    int          pend_ch;
    int          have_ch;
    always @(negedge clk) begin
        bit         arb;
        bit         found;
        int         w;
        logic [3:0] exp_ready;
        logic [1:0] exp_sat;
        if (rst) begin
            m_last = NUM_CH - 1;
            ce_exp = 1'b0;
            have   = 1'b0;
        end else begin
            arb = !ce_exp && (!have || out_ready);
            found = 1'b0;
            w = 0;
            for (int k = 1; k <= NUM_CH; k++) begin
                if (!found && in_valid[(m_last + k) % NUM_CH]) begin
                    found = 1'b1;
                    w = (m_last + k) % NUM_CH;
                end
            end
            exp_ready = (arb && found) ? (4'b0001 << w) : 4'b0000;
            check("in_ready", {60'h0, in_ready}, {60'h0, exp_ready});
            check("core_ce", {63'h0, core_ce}, {63'h0, ce_exp});
            check("out_valid", {63'h0, out_valid}, {63'h0, have});
            if (have) begin
`ifdef MS_SAT_FLAG_EN
                exp_sat = have_res[33:32];
`else
                exp_sat = 2'b00;
`endif
                check("out_L", {48'h0, out_L}, {48'h0, have_res[31:16]});
                check("out_R", {48'h0, out_R}, {48'h0, have_res[15:0]});
                check("out_ch", {62'h0, out_ch}, 64'(have_ch));
                check("out_sat", {62'h0, out_sat}, {62'h0, exp_sat});
            end
            if (ce_exp) begin
                have_res = pend_res;
                have_ch  = pend_ch;
                have     = 1'b1;
            end else begin
                have = have && !out_ready;
            end
            ce_exp = arb && found;
            if (arb && found) begin
                pend_res = core_fn(in_mid[16*w +: 16], in_side[16*w +: 16], ch_enable[w]);
                pend_ch  = w;
                m_last   = w;
                grant_q.push_back(w);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [15:0] m, input logic [15:0] s);
        in_mid[16*ch +: 16]  = m;
        in_side[16*ch +: 16] = s;
    endtask

    // Leaves the caller at the negedge where the channel is granted.
    task automatic wait_grant(input int ch);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = in_ready[ch];
            if (!got) tick();
        end
        check("grant_timeout", {63'h0, got}, 64'h1);
    endtask

    initial begin
        // Reset and idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("idle_ready", {60'h0, in_ready}, 64'h0);
        check("idle_valid", {63'h0, out_valid}, 64'h0);
        check("idle_sat", {62'h0, out_sat}, 64'h0);
        check("idle_ce", {63'h0, core_ce}, 64'h0);

        // Single sample on channel 2
        tick();
        set_ch(2, 16'h0100, 16'h0040);
        in_valid = 4'b0100;
        @(negedge clk);
        check("single_grant", {60'h0, in_ready}, 64'h4);
        tick();
        in_valid = 4'b0000;
        @(negedge clk);
        check("single_ce", {63'h0, core_ce}, 64'h1);
        tick();
        @(negedge clk);
        check("single_valid", {63'h0, out_valid}, 64'h1);
        check("single_L", {48'h0, out_L}, 64'h0140);
        check("single_R", {48'h0, out_R}, 64'h00C0);
        check("single_ch", {62'h0, out_ch}, 64'h2);
        tick();
        tick();

        // Round-robin after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        grant_q.delete();
        set_ch(0, 16'h1000, 16'h0001);
        set_ch(1, 16'hF000, 16'h0010);
        set_ch(2, 16'h0333, 16'h0111);
        set_ch(3, 16'h8001, 16'h0005);
        ch_enable = 4'b1011;
        in_valid = 4'hF;
        repeat (12) tick();
        check("rr_count", 64'(grant_q.size()), 64'd6);
        if (grant_q.size() >= 6) begin
            check("rr_g0", 64'(grant_q[0]), 64'd0);
            check("rr_g1", 64'(grant_q[1]), 64'd1);
            check("rr_g2", 64'(grant_q[2]), 64'd2);
            check("rr_g3", 64'(grant_q[3]), 64'd3);
            check("rr_g4", 64'(grant_q[4]), 64'd0);
            check("rr_g5", 64'(grant_q[5]), 64'd1);
        end

        // Backpressure while a result is pending
        out_ready = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                seen = out_valid;
                tick();
            end
            check("bp_valid_timeout", {63'h0, seen}, 64'h1);
        end
        repeat (5) begin
            @(negedge clk);
            check("bp_no_ready", {60'h0, in_ready}, 64'h0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", {63'h0, |in_ready}, 64'h1);
        tick();
        in_valid = 4'h0;
        repeat (4) tick();

        // Saturation, transform enabled then bypassed
        ch_enable = 4'hF;
        set_ch(1, 16'h7000, 16'h2000);
        in_valid = 4'b0010;
        wait_grant(1);
        tick();
        in_valid = 4'b0000;
        tick();
        @(negedge clk);
        check("sat_L", {48'h0, out_L}, 64'h7FFF);
        check("sat_R", {48'h0, out_R}, 64'h5000);
`ifdef MS_SAT_FLAG_EN
        check("sat_flags", {62'h0, out_sat}, 64'h1);
`else
        check("sat_flags", {62'h0, out_sat}, 64'h0);
`endif
        tick();
        ch_enable = 4'b1101;
        in_valid = 4'b0010;
        wait_grant(1);
        tick();
        in_valid = 4'b0000;
        tick();
        @(negedge clk);
        check("byp_L", {48'h0, out_L}, 64'h7000);
        check("byp_R", {48'h0, out_R}, 64'h2000);
        check("byp_flags", {62'h0, out_sat}, 64'h0);
        tick();
        tick();

        // Reset while in ISSUE
        in_valid = 4'b0010;
        wait_grant(1);
        tick();
        in_valid = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 4'b1001;
        @(negedge clk);
        check("rst_issue_valid", {63'h0, out_valid}, 64'h0);
        check("rst_first_grant", {60'h0, in_ready}, 64'h1);
        tick();
        in_valid = 4'b0000;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/ms_inverse_scheduler.md
# ms_inverse_scheduler

Round-robin scheduler that time-shares a single `mid_side_inverse` core among `NUM_CH` stereo mid/side streams. Each stream has its own valid/ready input. The block arbitrates between the streams, registers the winner's operands, pulses the core's `ce` for exactly one cycle, and presents the core's registered L/R result on a single tagged valid/ready output. It sits between the per-channel decoder FIFOs and the output mixer.

## Interface
Parameters:
- `NUM_CH`, default 4: number of requesting channels, range 2–16. `CH_W = $clog2(NUM_CH)` is a localparam.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in NUM_CH: per-channel sample valid.
- `in_ready` out NUM_CH: one-hot grant; a handshake completes where `in_valid[i] & in_ready[i]`.
- `in_mid` in 16*NUM_CH: signed mid sample; channel i occupies bits [16i+15:16i].
- `in_side` in 16*NUM_CH: signed side sample, same packing as `in_mid`.
- `ch_enable` in NUM_CH: per-channel inverse-transform enable; 0 selects core bypass.
- `core_ce` out 1: clock enable to the core.
- `core_enable` out 1: transform enable to the core.
- `core_mid` out 16: operand to the core.
- `core_side` out 16: operand to the core.
- `core_L` in 16: registered result from the core.
- `core_R` in 16: registered result from the core.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accept.
- `out_L` out 16: result L.
- `out_R` out 16: result R.
- `out_ch` out CH_W: channel tag of the current result.
- `out_sat` out 2: saturation flags, bit0 = L, bit1 = R. Always present; see Configuration.

## Operation
- FSM states: IDLE, ISSUE, OUT.
- **Arbitration.** Performed in IDLE, and in OUT on the cycle where `out_valid & out_ready`.
  - Winner is the first asserted `in_valid` searching from `last_grant+1` upward, with wrap-around.
  - `in_ready[winner]` is asserted combinationally in that cycle. `in_ready` is never asserted in any other cycle.
  - On a grant, the block registers the winner's mid, side, `ch_enable` bit and index into operand registers, and updates `last_grant`.
- **IDLE.** Grant → ISSUE. No `in_valid` → stay in IDLE.
- **ISSUE.**
  - `core_ce = 1` for this single cycle.
  - `core_mid`, `core_side` and `core_enable` are driven from the operand registers.
  - Next state is OUT.
- **OUT.**
  - `out_valid = 1`.
  - `out_L`/`out_R` are driven directly from `core_L`/`core_R`. These stay stable because `core_ce = 0` outside ISSUE.
  - `out_ch` is the operand channel index.
  - On `out_ready`: a grant → ISSUE, no grant → IDLE. Without `out_ready`, stay in OUT and hold every output.
- `core_mid`, `core_side` and `core_enable` hold the last operands when `core_ce = 0`.
- Bypass is carried through unchanged: `ch_enable = 0` yields `out_L = mid` and `out_R = side`.
- Channels whose `in_valid` deasserts before being granted are skipped with no penalty.
- **Reset values:**
  - state = IDLE;
  - `last_grant` = NUM_CH-1, so channel 0 wins first;
  - operand registers 0;
  - `core_ce` 0, `core_enable` 0;
  - `in_ready` 0, `out_valid` 0, `out_ch` 0, `out_sat` 0.
  - `out_L`/`out_R` are don't-care while `out_valid = 0`.
- **Reset mid-operation.** Any in-flight sample is dropped: no `out_valid` and no further `core_ce`. The next grant after reset goes to channel 0.

## Timing
- **Latency.** Handshake in cycle t → `core_ce` in t+1 → `out_valid` in t+2.
- **Throughput.** With `out_ready` held at 1 and inputs always valid, one result every 2 cycles.
- **Fairness.** With all channels continuously valid, each channel is granted once per NUM_CH grants.
- **Backpressure.** The next grant occurs no earlier than the `out_ready` cycle. The core is never clocked while a result is unconsumed.
- **Simultaneous events.** Output acceptance and a new grant in the same cycle is legal and required.

## Configuration
- **`MS_SAT_FLAG_EN` defined.**
  - In ISSUE, compute 17-bit `mid+side` and `mid-side` from the operand registers.
  - Register `out_sat[0]` = L sum outside [-32768, 32767] and `out_sat[1]` = R difference outside that range, both gated by `core_enable`.
  - Flags are valid with `out_valid`; reset value 0.
- **`MS_SAT_FLAG_EN` undefined.** `out_sat` is tied to 2'b00 and no detection logic is built.

## Test plan
- **Reset and idle.** Hold `rst` for 2 cycles, then keep all `in_valid = 0` → `in_ready`, `core_ce`, `out_valid` and `out_sat` stay 0 indefinitely.
- **Single sample.** Ch2 issues mid=0x0100, side=0x0040, enable=1 at cycle t → `core_ce` at t+1; `out_valid` at t+2 with L=0x0140, R=0x00C0, `out_ch` = 2.
- **Round-robin.** All 4 channels continuously valid, `out_ready = 1` → grant order 0,1,2,3,0,1; one `out_valid` every 2 cycles.
- **Backpressure.** `out_ready = 0` for 5 cycles while OUT → outputs held stable, no `in_ready`, no `core_ce`. `out_ready = 1` → the next grant occurs in that same cycle.
- **Saturation (macro defined).** mid=0x7000, side=0x2000, enable=1 → L=0x7FFF, R=0x5000, `out_sat` = 2'b01. Same sample with enable=0 → L=0x7000, R=0x2000, `out_sat` = 2'b00.
- **Reset in ISSUE.** Assert `rst` while in ISSUE → no `out_valid` follows. After release with ch0 and ch3 valid, ch0 is granted first.
